// File: rtl/risc_ctrl_if.sv
// rtl/risc_ctrl_if.sv - sequencer <-> datapath signal bundle (resume present with CTRL_RESUME_EN)
interface risc_ctrl_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       load_ir;
  logic       load_acc;
  logic       inc_pc;
  logic       load_pc;
  logic       halt;
  logic [2:0] phase;
`ifdef CTRL_RESUME_EN
  logic       resume;

  modport master (
    output opcode, zero, resume,
    input  mem_rd, mem_wr, load_ir, load_acc, inc_pc, load_pc, halt, phase
  );
  modport slave (
    input  opcode, zero, resume,
    output mem_rd, mem_wr, load_ir, load_acc, inc_pc, load_pc, halt, phase
  );
`else
  modport master (
    output opcode, zero,
    input  mem_rd, mem_wr, load_ir, load_acc, inc_pc, load_pc, halt, phase
  );
  modport slave (
    input  opcode, zero,
    output mem_rd, mem_wr, load_ir, load_acc, inc_pc, load_pc, halt, phase
  );
`endif
endinterface

// File: rtl/risc_ctrl.sv
// rtl/risc_ctrl.sv - 8-phase RISC instruction sequencer; CTRL_RESUME_EN adds resume-from-halt
module risc_ctrl #(
  parameter int NPHASE = 8
) (
  input logic         clk,
  input logic         rst_,
  risc_ctrl_if.slave  bus
);
  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;
  localparam logic [2:0] LAST_PHASE = 3'(NPHASE - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_phase, w_phase_nxt;
  logic       r_mem_rd, r_mem_wr, r_load_ir, r_load_acc, r_inc_pc, r_load_pc, r_halt;
  logic       w_mem_rd, w_mem_wr, w_load_ir, w_load_acc, w_inc_pc, w_load_pc, w_halt;
  logic       w_aluop;
  logic       w_resume;

`ifdef CTRL_RESUME_EN
  assign w_resume = bus.resume;
`else
  assign w_resume = 1'b0;
`endif

  assign w_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    if (r_state == ST_HALTED) begin
      if (w_resume) begin
        w_state_nxt = ST_RUN;
        w_phase_nxt = 3'd0;
      end
    end else if (r_phase == 3'd4 && bus.opcode == OP_HLT) begin
      w_state_nxt = ST_HALTED;
    end else begin
      w_phase_nxt = (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;
    end
  end

  // Strobes are decoded for the phase being entered so they are registered at its start.
  always_comb begin
    w_mem_rd   = 1'b0;
    w_mem_wr   = 1'b0;
    w_load_ir  = 1'b0;
    w_load_acc = 1'b0;
    w_inc_pc   = 1'b0;
    w_load_pc  = 1'b0;
    w_halt     = 1'b0;
    if (w_state_nxt == ST_HALTED) begin
      w_halt = 1'b1;
    end else begin
      case (w_phase_nxt)
        3'd1: w_mem_rd = 1'b1;
        3'd2, 3'd3: begin
          w_mem_rd  = 1'b1;
          w_load_ir = 1'b1;
        end
        3'd4: begin
          w_inc_pc = 1'b1;
          w_halt   = (bus.opcode == OP_HLT);
        end
        3'd5: w_mem_rd = w_aluop;
        3'd6: begin
          w_mem_rd   = w_aluop;
          w_load_acc = w_aluop;
          w_inc_pc   = (bus.opcode == OP_SKZ) && bus.zero;
          w_load_pc  = (bus.opcode == OP_JMP);
        end
        3'd7: begin
          w_mem_rd   = w_aluop;
          w_load_acc = w_aluop;
          w_inc_pc   = (bus.opcode == OP_JMP);
          w_load_pc  = (bus.opcode == OP_JMP);
          w_mem_wr   = (bus.opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_RUN;
      r_phase    <= 3'd0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_load_ir  <= 1'b0;
      r_load_acc <= 1'b0;
      r_inc_pc   <= 1'b0;
      r_load_pc  <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_mem_rd   <= w_mem_rd;
      r_mem_wr   <= w_mem_wr;
      r_load_ir  <= w_load_ir;
      r_load_acc <= w_load_acc;
      r_inc_pc   <= w_inc_pc;
      r_load_pc  <= w_load_pc;
      r_halt     <= w_halt;
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_wr   = r_mem_wr;
  assign bus.load_ir  = r_load_ir;
  assign bus.load_acc = r_load_acc;
  assign bus.inc_pc   = r_inc_pc;
  assign bus.load_pc  = r_load_pc;
  assign bus.halt     = r_halt;
  assign bus.phase    = r_phase;
endmodule

// File: tb/tb_risc_ctrl.sv
// tb/tb_risc_ctrl.sv - scoreboard bench for risc_ctrl against an instruction-level model
module tb_risc_ctrl;
  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       load_ir;
    logic       load_acc;
    logic       inc_pc;
    logic       load_pc;
    logic       halt;
    logic [2:0] phase;
  } out_t;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;
`ifdef CTRL_RESUME_EN
  localparam bit RESUME_EN = 1'b1;
`else
  localparam bit RESUME_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  risc_ctrl_if bus();

  risc_ctrl dut (.clk(clk), .rst_(rst_), .bus(bus));

  always #5 clk = ~clk;

  out_t q_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_phase = 0;
  bit   m_halted = 1'b0;

  function automatic out_t dut_out();
    return {bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_acc,
            bus.inc_pc, bus.load_pc, bus.halt, bus.phase};
  endfunction

  // What the outputs must read while sitting in phase ph of an instruction op.
  function automatic out_t model_out(int ph, bit hl, logic [2:0] op, bit z);
    out_t o = '0;
    bit   alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
    if (hl) begin
      o.halt  = 1'b1;
      o.phase = 3'd4;
      return o;
    end
    o.phase    = 3'(ph);
    o.mem_rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    o.load_ir  = (ph == 2 || ph == 3);
    o.load_acc = (ph >= 6) && alu;
    o.inc_pc   = (ph == 4) || (ph == 6 && op == SKZ && z) || (ph == 7 && op == JMP);
    o.load_pc  = (ph >= 6) && (op == JMP);
    o.mem_wr   = (ph == 7) && (op == STO);
    o.halt     = (ph == 4) && (op == HLT);
    return o;
  endfunction

  task automatic step(input logic [2:0] op_i, input bit z_i, input bit rst_i, input bit res_i);
    @(negedge clk);
    bus.opcode = op_i;
    bus.zero   = z_i;
    rst_       = rst_i;
`ifdef CTRL_RESUME_EN
    bus.resume = res_i;
`endif
    if (!rst_i) begin
      m_phase  = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      if (res_i && RESUME_EN) begin
        m_halted = 1'b0;
        m_phase  = 0;
      end
    end else if (m_phase == 4 && op_i == HLT) begin
      m_halted = 1'b1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
    q_exp.push_back(model_out(m_phase, m_halted, op_i, z_i));
  endtask

  // One 8-edge instruction; opcode/zero are only meaningful when the sequencer samples them.
  task automatic run_instr(input logic [2:0] op, input bit zv, input int n_edges);
    for (int k = 0; k < n_edges; k++) begin
      logic [2:0] o_d;
      bit         z_d;
      o_d = (m_phase >= 3 && m_phase <= 6) ? op : 3'($urandom_range(7, 0));
      z_d = (m_phase == 5) ? zv : 1'($urandom_range(1, 0));
      step(o_d, z_d, 1'b1, 1'b0);
    end
  endtask

  task automatic run_hlt();
    for (int k = 0; k < 8 && !m_halted; k++) begin
      logic [2:0] o_d;
      o_d = (m_phase >= 3 && m_phase <= 6) ? HLT : 3'($urandom_range(7, 0));
      step(o_d, 1'($urandom_range(1, 0)), 1'b1, 1'b0);
    end
    for (int k = 0; k < 22; k++)
      step((k % 3 == 0) ? ADD : 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'b1, 1'b0);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin : monitor
    out_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        a = dut_out();
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_out t=%0t rd,wr,ir,acc,inc,ldpc,halt,phase actual=%b required=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] fixed_ops [8];
    bit         fixed_z [8];
    bus.opcode = ADD;
    bus.zero   = 1'b0;
`ifdef CTRL_RESUME_EN
    bus.resume = 1'b0;
`endif
    fixed_ops = '{ADD, SKZ, SKZ, STO, JMP, AND_, XOR_, LDA};
    fixed_z   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    step(ADD, 1'b0, 1'b0, 1'b0);
    step(ADD, 1'b1, 1'b0, 1'b0);
    #2;
    check("reset_phase", int'(bus.phase), 0);
    check("reset_strobes", int'({bus.mem_rd, bus.mem_wr, bus.load_ir, bus.load_acc,
                                 bus.inc_pc, bus.load_pc, bus.halt}), 0);

    for (int i = 0; i < 8; i++) run_instr(fixed_ops[i], fixed_z[i], 8);
    for (int i = 0; i < 30; i++)
      run_instr(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), 8);

    run_hlt();
    check("halt_held", int'(bus.halt), 1);
    check("halt_phase", int'(bus.phase), 4);
    if (RESUME_EN) begin
      step(ADD, 1'b0, 1'b1, 1'b1);
      run_instr(ADD, 1'b0, 8);
    end else begin
      step(ADD, 1'b0, 1'b0, 1'b0);
      step(ADD, 1'b0, 1'b1, 1'b0);
      run_instr(ADD, 1'b0, 7);
    end

    for (int i = 0; i < 10; i++)
      run_instr(3'($urandom_range(7, 1)), 1'($urandom_range(1, 0)), 8);

    run_instr(STO, 1'b0, 7);
    @(posedge clk);
    #2;
    check("sto_ph7_mem_wr", int'(bus.mem_wr), 1);
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    check("async_rst_mem_wr", int'(bus.mem_wr), 0);
    check("async_rst_phase", int'(bus.phase), 0);
    m_phase  = 0;
    m_halted = 1'b0;
    q_exp.push_back(model_out(0, 1'b0, STO, 1'b0));
    step(ADD, 1'b0, 1'b1, 1'b0);
    run_instr(ADD, 1'b0, 7);
    run_hlt();

    @(posedge clk);
    @(posedge clk);
    #2;
    check("queue_drained", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
